// File: rtl/cpu_player_if.sv
// Groups the player's game-side signals: enable/rnd/level in, press/press_cnt out.
// Latency: none (wires only).
// Backpressure: none; press is a fire-and-forget pulse.
//
// Ports (signals):
//   enable    - game active; 0 freezes the player
//   rnd       - 10-bit pseudo-random value from the upstream LFSR
//   level     - 9-bit difficulty threshold; larger presses more often
//   press     - one-cycle press pulse toward the tug-of-war input path
//   press_cnt - saturating count of presses issued
`timescale 1ns/1ps
interface cpu_player_if;
    logic       enable;
    logic [9:0] rnd;
    logic [8:0] level;
    logic       press;
    logic [7:0] press_cnt;

    // master drives the game controls and observes the player
    modport master (
        output enable, rnd, level,
        input  press, press_cnt
    );

    // slave is the player itself
    modport slave (
        input  enable, rnd, level,
        output press, press_cnt
    );
endinterface

// File: rtl/cpu_player.sv
// Computer opponent: every TICK_DIV enabled cycles, presses if level > rnd, then rests COOL_TICKS ticks.
// Latency: press is registered, high the cycle after the deciding tick; press_cnt updates with it.
// Backpressure: none; enable=0 freezes and clears the decision logic (press_cnt is kept).
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   enable    - game active
//   rnd       - 10-bit LFSR value, sampled only in a tick cycle while IDLE
//   level     - 9-bit threshold; hit = {1'b0,level} > rnd
//   press     - one-cycle press pulse (registered, no combinational input path)
//   press_cnt - presses issued, saturating at 255
`timescale 1ns/1ps
module cpu_player #(
    parameter int TICK_DIV   = 1024,
    parameter int COOL_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] rnd,
    input  logic [8:0] level,
    output logic       press,
    output logic [7:0] press_cnt
);

    // A one-bit counter is still needed when TICK_DIV is 2.
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]    COOL_LOAD = 4'(COOL_TICKS);

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    logic [TW-1:0] tick_cnt_q,  tick_cnt_d;
    state_t        state_q,     state_d;
    logic [3:0]    cool_cnt_q,  cool_cnt_d;
    logic          press_q,     press_d;
    logic [7:0]    press_cnt_q, press_cnt_d;

    logic tick;
    logic hit;

    // Decision strobe: last count of the prescaler while enabled.
    assign tick = enable && (tick_cnt_q == TICK_LAST);

    // Zero-extended level so level=511 still loses against rnd=511..1023.
    assign hit = ({1'b0, level} > rnd);

    // Prescaler. Compare-and-wrap rather than natural overflow so that
    // non-power-of-two TICK_DIV values keep the exact period.
    always_comb begin
        tick_cnt_d = '0;
        if (enable) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Next-state / output logic.
    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        press_d    = 1'b0;

        if (!enable) begin
            // Disabling abandons any cooldown; an already registered
            // press still shows for its one cycle because press_q is
            // simply not reloaded with 1.
            state_d    = IDLE;
            cool_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        press_d    = 1'b1;
                        state_d    = COOL;
                        cool_cnt_d = COOL_LOAD;
                    end
                end
                COOL: begin
                    // The tick that drains the counter hands control back;
                    // the following tick is the first evaluation.
                    if (cool_cnt_q <= 4'd1) begin
                        cool_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    cool_cnt_d = '0;
                end
            endcase
        end
    end

    // Counted off press_d so the count is already updated in the cycle
    // press is visible.
    always_comb begin
        press_cnt_d = press_cnt_q;
        if (press_d && (press_cnt_q != 8'hFF)) begin
            press_cnt_d = press_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            state_q     <= IDLE;
            cool_cnt_q  <= '0;
            press_q     <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            state_q     <= state_d;
            cool_cnt_q  <= cool_cnt_d;
            press_q     <= press_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press     = press_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_cpu_player.sv
// Bench for cpu_player with TICK_DIV=4, COOL_TICKS=2: directed scenarios plus random traffic
// Latency: checks press/press_cnt 1ns after every rising edge against a tick-counting model.
// Backpressure: none; inputs are driven on the falling edge.
`timescale 1ns/1ps
module tb_cpu_player;

    localparam int TDIV  = 4;
    localparam int CTICK = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cpu_player_if bus ();

    cpu_player #(
        .TICK_DIV   (TDIV),
        .COOL_TICKS (CTICK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .rnd       (bus.rnd),
        .level     (bus.level),
        .press     (bus.press),
        .press_cnt (bus.press_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: counts enabled cycles since the last reset/disable,
    // a tick is every TDIV-th such cycle, and after a press the next
    // CTICK ticks are skipped.
    int m_en_cycles = 0;
    int m_skip      = 0;
    int m_cnt       = 0;
    int m_press     = 0;
    logic prev_press = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en_cycles = 0;
        m_skip      = 0;
        m_cnt       = 0;
        m_press     = 0;
    endtask

    task automatic model_step(input logic en, input int r, input int lv);
        m_press = 0;
        if (!en) begin
            m_en_cycles = 0;
            m_skip      = 0;
        end else begin
            m_en_cycles++;
            if (m_en_cycles % TDIV == 0) begin
                if (m_skip > 0) begin
                    m_skip--;
                end else if (lv > r) begin
                    m_press = 1;
                    m_skip  = CTICK;
                    if (m_cnt < 255) m_cnt++;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input logic en, input logic [9:0] r, input logic [8:0] lv);
        @(negedge clk);
        bus.enable = en;
        bus.rnd    = r;
        bus.level  = lv;
        model_step(en, int'(r), int'(lv));
        @(posedge clk);
        #1;
        chk("press", int'(bus.press), m_press);
        chk("press_cnt", int'(bus.press_cnt), m_cnt);
        chk("no_consec_press", int'(prev_press & bus.press), 0);
        prev_press = bus.press;
    endtask

    // Reset with enable low so the edge at deassertion is a no-op for the model.
    task automatic do_reset();
        bus.enable = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_press", int'(bus.press), 0);
        chk("rst_press_cnt", int'(bus.press_cnt), 0);
        chk("rst_tick_cnt", int'(dut.tick_cnt_q), 0);
        model_reset();
        prev_press = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic       en;
        logic [9:0] r;
        logic [8:0] lv;
        int         sel;
        int         guard;

        bus.enable = 1'b0;
        bus.rnd    = '0;
        bus.level  = '0;

        // Reset state
        do_reset();

        // Scenario 1: presses after ticks 1, 4, 7 -> 3 presses in 9 ticks
        for (int i = 0; i < 9 * TDIV; i++) cyc(1'b1, 10'd50, 9'd100);
        chk("s1_press_cnt", int'(bus.press_cnt), 3);

        // Scenario 2: level 0 never presses
        do_reset();
        for (int i = 0; i < 20 * TDIV; i++) cyc(1'b1, 10'd0, 9'd0);
        chk("s2_press_cnt", int'(bus.press_cnt), 0);

        // Scenario 3: rnd=1023 never loses, then rnd=510 presses on the next tick
        for (int i = 0; i < 5 * TDIV; i++) cyc(1'b1, 10'd1023, 9'd511);
        chk("s3_no_press_cnt", int'(bus.press_cnt), 0);
        for (int i = 0; i < TDIV; i++) cyc(1'b1, 10'd510, 9'd511);
        chk("s3_press", int'(bus.press), 1);
        chk("s3_press_cnt", int'(bus.press_cnt), 1);

        // Scenario 4: enable dropped mid-cooldown
        do_reset();
        for (int i = 0; i < TDIV; i++) cyc(1'b1, 10'd50, 9'd100);
        chk("s4_first_press", int'(bus.press), 1);
        for (int i = 0; i < TDIV + 1; i++) cyc(1'b1, 10'd50, 9'd100);
        chk("s4_in_cool", int'(dut.cool_cnt_q), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 10'd50, 9'd100);
        chk("s4_tick_cnt", int'(dut.tick_cnt_q), 0);
        chk("s4_cool_cnt", int'(dut.cool_cnt_q), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 10'd50, 9'd100);
        chk("s4_quiet", int'(bus.press), 0);
        cyc(1'b1, 10'd50, 9'd100);
        chk("s4_eval", int'(bus.press), 1);
        chk("s4_press_cnt", int'(bus.press_cnt), 2);

        // Scenario 5: async reset inside the press cycle
        guard = 0;
        while (bus.press !== 1'b1 && guard < 40) begin
            cyc(1'b1, 10'd50, 9'd100);
            guard++;
        end
        chk("s5_press_seen", int'(bus.press), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("s5_async_press", int'(bus.press), 0);
        chk("s5_async_press_cnt", int'(bus.press_cnt), 0);
        bus.enable = 1'b0;
        model_reset();
        prev_press = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Scenario 6: saturation at 255
        for (int i = 0; i < 900 * TDIV; i++) cyc(1'b1, 10'd50, 9'd100);
        chk("s6_saturated", int'(bus.press_cnt), 255);

        // Random traffic with boundary values and occasional disables
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            r   = 10'($urandom_range(0, 1023));
            lv  = 9'($urandom_range(0, 511));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) lv = 9'd0;
            if (sel == 1) lv = 9'd511;
            if (sel == 2) r  = 10'd1023;
            if (sel == 3) r  = 10'($urandom_range(0, 15));
            cyc(en, r, lv);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
